cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/halt/single-step sequencer for the single-cycle CPU core. It gates PC advance and register-file writeback so a host can start, stop, single-step or cycle-limit program execution. It stops on a halt opcode and traps on register-file parity errors. It sits beside the PC and the control unit: `pc_en` qualifies the PC update, and `wb_en` is ANDed with the control unit's `reg_write`.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter and the limit.
- `HALT_OPCODE`, default 4'hF: decoded opcode that stops execution.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: level-sampled; begin free run from IDLE/HALTED.
- `stop` in 1: level-sampled; halt before the current instruction retires.
- `step` in 1: level-sampled; execute exactly one instruction from IDLE/HALTED.
- `cycle_limit` in CNT_W: retire budget per run; 0 means unlimited.
- `opcode` in 4: decoded opcode of the instruction at the current PC.
- `pc_value` in 32: current PC.
- `parity_error` in 1: register-file parity error.
- `pc_en` out 1: PC may advance this cycle (combinational).
- `wb_en` out 1: writeback permitted this cycle (combinational; equals `pc_en`).
- `busy` out 1: state is RUN or STEP.
- `done` out 1: one-cycle pulse on entry to HALTED.
- `fault` out 1: sticky; state is FAULT.
- `halt_cause` out 2: 00 none, 01 halt opcode, 10 host stop/step, 11 limit reached.
- `halt_pc` out 32: address of the first unexecuted instruction.
- `cycle_count` out CNT_W: instructions retired in the current run.

## Operation
- States: IDLE, RUN, STEP, HALTED, FAULT.
- Retire condition: `retire = (RUN|STEP) & !trap & opcode!=HALT_OPCODE & !stop`. `pc_en = wb_en = retire`.
- IDLE/HALTED:
  - `start` -> RUN; clears `cycle_count` and `halt_cause`.
  - else `step` -> STEP, with the same clears.
  - `start` has priority over `step`. `stop` is ignored in these states.
- RUN, priority per cycle:
  - trap -> FAULT.
  - else `opcode==HALT_OPCODE` -> HALTED, cause 01.
  - else `stop` -> HALTED, cause 10.
  - else retire. If `cycle_limit!=0` and `cycle_count+1==cycle_limit`, go to HALTED with cause 11; otherwise stay in RUN.
- STEP: same priority as RUN. After one retire, go to HALTED with cause 10 (or cause 11 if the limit is hit simultaneously).
- `start`/`step` in RUN or STEP are ignored.
- `cycle_count` increments by 1 per retire and wraps modulo 2^CNT_W. The limit compare uses the pre-increment value + 1 at CNT_W bits.
- `halt_pc` is loaded from `pc_value` on the first cycle in HALTED, so it equals the PC after the last retire. For cause 01 this is the PC of the halt instruction.
- FAULT: `fault=1`, `pc_en=0`. Only `rst_n` exits FAULT; `start`/`step` are ignored.
- `done` is a registered one-cycle pulse, high in the first HALTED cycle, from either RUN or STEP.

## Timing
- Reset values: state IDLE, `pc_en` 0, `wb_en` 0, `busy` 0, `done` 0, `fault` 0, `halt_cause` 00, `halt_pc` 0, `cycle_count` 0.
- `rst_n` low forces reset values asynchronously at any time, including mid-RUN. The first `start` is accepted on the first rising edge with `rst_n` high.
- Command latency: `start`/`step` sampled at edge N; `pc_en` can be high in cycle N+1.
- Stop latency: `stop`, halt opcode and trap deassert `pc_en` combinationally in the same cycle. The state changes at the next edge.
- A limit halt retires the final instruction in the cycle the limit is reached; `pc_en` is 0 from the next cycle.

## Configuration
- `RUN_CTRL_PARITY_TRAP_EN` defined:
  - trap = `parity_error` in RUN/STEP; it blocks retire that cycle and enters FAULT.
  - `parity_error` in IDLE/HALTED is ignored.
- Not defined:
  - `parity_error` is ignored and `fault` is tied 0.
  - FAULT is unreachable and need not be implemented.

## Test plan
- Halt opcode: reset, `cycle_limit=0`, `start`, opcode 4'h1 for 4 cycles then 4'hF at PC 0x10 -> `pc_en` high 4 cycles, `done` pulse, cause 01, `cycle_count=4`, `halt_pc=0x10`.
- Cycle limit: `cycle_limit=3`, `start`, never a halt opcode -> exactly 3 `pc_en` cycles, cause 11, `cycle_count=3`, `busy` low after.
- Single step: from IDLE, `step` -> one `pc_en` cycle, HALTED, cause 10, count 1. A second `step` with opcode 4'hF -> zero `pc_en` cycles, cause 01, count 0.
- Host stop: `stop` asserted in the 3rd RUN cycle -> `pc_en` low that same cycle, count 2, cause 10. A following `start` resumes with count cleared to 0.
- Parity trap: with macro, `parity_error` in RUN -> `pc_en` 0 that cycle, `fault=1`, `start` ignored, cleared only by `rst_n`. Without macro -> execution continues and `fault` stays 0.
- Async reset: `rst_n` low mid-RUN between clock edges -> all outputs reach reset values immediately; `start` after release runs from count 0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer gating PC advance and writeback for the single-cycle core.
// Optional parity trap enabled by defining RUN_CTRL_PARITY_TRAP_EN.
module cpu_run_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [3:0]       opcode,
  input  logic [31:0]      pc_value,
  input  logic             parity_error,
  output logic             pc_en,
  output logic             wb_en,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       halt_cause,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED,
    S_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_HOST  = 2'b10;
  localparam logic [1:0] CAUSE_LIMIT = 2'b11;

  state_t           state, state_next;
  logic [1:0]       cause, cause_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [31:0]      hpc;
  logic             done_q;
  logic             active, trap, is_halt_op, retire, limit_hit, launch;

  assign active     = (state == S_RUN) || (state == S_STEP);
  assign is_halt_op = (opcode == HALT_OPCODE);
  assign count_inc  = count + CNT_W'(1);
  assign limit_hit  = (cycle_limit != '0) && (count_inc == cycle_limit);
  assign launch     = ((state == S_IDLE) || (state == S_HALTED)) && (start || step);
  assign retire     = active && !trap && !is_halt_op && !stop;

`ifdef RUN_CTRL_PARITY_TRAP_EN
  assign trap = active && parity_error;
`else
  logic unused_parity;
  assign unused_parity = parity_error;
  assign trap          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_next = S_RUN;
          cause_next = CAUSE_NONE;
        end else if (step) begin
          state_next = S_STEP;
          cause_next = CAUSE_NONE;
        end
      end
      S_RUN, S_STEP: begin
        if (trap) begin
          state_next = S_FAULT;
        end else if (is_halt_op) begin
          state_next = S_HALTED;
          cause_next = CAUSE_HALT;
        end else if (stop) begin
          state_next = S_HALTED;
          cause_next = CAUSE_HOST;
        end else if (limit_hit) begin
          state_next = S_HALTED;
          cause_next = CAUSE_LIMIT;
        end else if (state == S_STEP) begin
          state_next = S_HALTED;
          cause_next = CAUSE_HOST;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en = retire;
    wb_en = retire;
    busy  = active;
`ifdef RUN_CTRL_PARITY_TRAP_EN
    fault = (state == S_FAULT);
`else
    fault = 1'b0;
`endif
  end

  // halt_pc samples during the first HALTED cycle, when the PC has already
  // taken the final retire's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause  <= CAUSE_NONE;
      count  <= '0;
      hpc    <= '0;
      done_q <= 1'b0;
    end else begin
      cause  <= cause_next;
      done_q <= active && (state_next == S_HALTED);
      if (launch) begin
        count <= '0;
      end else if (retire) begin
        count <= count_inc;
      end
      if (done_q) begin
        hpc <= pc_value;
      end
    end
  end

  assign done        = done_q;
  assign halt_cause  = cause;
  assign halt_pc     = hpc;
  assign cycle_count = count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized episodes
// against a behavioural model. Honours RUN_CTRL_PARITY_TRAP_EN like the design.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [31:0] cycle_limit = '0;
  logic [3:0]  opcode = 4'h0;
  logic [31:0] pc_value = '0;
  logic        parity_error = 1'b0;
  logic        pc_en, wb_en, busy, done, fault;
  logic [1:0]  halt_cause;
  logic [31:0] halt_pc, cycle_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] pc = '0;
  logic        s_pc_en, s_wb_en, s_busy, s_done, s_fault;
  logic [1:0]  s_cause;
  logic [31:0] s_hpc, s_count;

  cpu_run_ctrl #(.CNT_W(32), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .cycle_limit(cycle_limit), .opcode(opcode), .pc_value(pc_value),
    .parity_error(parity_error), .pc_en(pc_en), .wb_en(wb_en), .busy(busy),
    .done(done), .fault(fault), .halt_cause(halt_cause), .halt_pc(halt_pc),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // One core cycle: drive inputs just after the rising edge, sample at the falling edge.
  task automatic cycle(input logic st, input logic sp, input logic stp,
                       input logic [3:0] op, input logic par);
    start = st; stop = sp; step = stp; opcode = op; parity_error = par;
    pc_value = pc;
    @(negedge clk);
    s_pc_en = pc_en; s_wb_en = wb_en; s_busy = busy; s_done = done;
    s_fault = fault; s_cause = halt_cause; s_hpc = halt_pc; s_count = cycle_count;
    @(posedge clk);
    if (s_pc_en) pc = pc + 32'd1;
    #1;
  endtask

  task automatic apply_reset();
    start = 0; stop = 0; step = 0; parity_error = 0; opcode = 4'h0;
    rst_n = 0;
    #7;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; opcode = 4'h2;
    #3;
    checks++;
    if ({pc_en, wb_en, busy, done, fault} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000", {pc_en, wb_en, busy, done, fault});
    end
    checks++;
    if (halt_cause !== 2'b00 || halt_pc !== 32'h0 || cycle_count !== 32'h0) begin
      errors++; $display("FAIL reset_regs cause=%0d hpc=%h cnt=%0d want 0/0/0", halt_cause, halt_pc, cycle_count);
    end
    apply_reset();
    cycle(0, 0, 0, 4'h2, 0);
    checks++;
    if (s_busy !== 1'b0 || s_pc_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b pc_en=%b want 0/0", s_busy, s_pc_en);
    end
  endtask

  task automatic test_halt_opcode();
    int pe = 0;
    cycle_limit = 0; pc = 32'h0C;
    cycle(1, 0, 0, 4'h1, 0);
    checks++;
    if (s_pc_en !== 1'b0) begin errors++; $display("FAIL halt_idle_pc_en got=%b want=0", s_pc_en); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 4'h1, 0);
      if (s_pc_en) pe++;
      checks++;
      if (s_wb_en !== s_pc_en) begin errors++; $display("FAIL halt_wb_en got=%b want=%b", s_wb_en, s_pc_en); end
    end
    checks++;
    if (pe != 4) begin errors++; $display("FAIL halt_pc_en_cycles got=%0d want=4", pe); end
    cycle(0, 0, 0, 4'hF, 0);
    checks++;
    if (s_pc_en !== 1'b0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL halt_op_cycle pc_en=%b busy=%b want 0/1", s_pc_en, s_busy);
    end
    cycle(0, 0, 0, 4'h3, 0);
    checks++;
    if (s_done !== 1'b1 || s_cause !== 2'b01 || s_count !== 32'd4 || s_busy !== 1'b0) begin
      errors++; $display("FAIL halt_result done=%b cause=%0d cnt=%0d busy=%b want 1/1/4/0", s_done, s_cause, s_count, s_busy);
    end
    cycle(0, 0, 0, 4'h3, 0);
    checks++;
    if (s_hpc !== 32'h10 || s_done !== 1'b0) begin
      errors++; $display("FAIL halt_pc got=%h done=%b want 00000010/0", s_hpc, s_done);
    end
  endtask

  task automatic test_cycle_limit();
    int pe = 0;
    int dn = 0;
    cycle_limit = 3;
    cycle(1, 0, 0, 4'h2, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 4'h2, 0);
      if (s_pc_en) pe++;
      if (s_done) dn++;
    end
    checks++;
    if (pe != 3 || dn != 1) begin errors++; $display("FAIL limit_cycles pc_en=%0d done=%0d want 3/1", pe, dn); end
    checks++;
    if (s_cause !== 2'b11 || s_count !== 32'd3 || s_busy !== 1'b0) begin
      errors++; $display("FAIL limit_result cause=%0d cnt=%0d busy=%b want 3/3/0", s_cause, s_count, s_busy);
    end
    cycle_limit = 0;
  endtask

  task automatic test_single_step();
    int pe = 0;
    cycle(0, 0, 1, 4'h2, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 4'h2, 0);
      if (s_pc_en) pe++;
    end
    checks++;
    if (pe != 1 || s_cause !== 2'b10 || s_count !== 32'd1) begin
      errors++; $display("FAIL step_one pc_en=%0d cause=%0d cnt=%0d want 1/2/1", pe, s_cause, s_count);
    end
    pe = 0;
    cycle(0, 0, 1, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 4'hF, 0);
      if (s_pc_en) pe++;
    end
    checks++;
    if (pe != 0 || s_cause !== 2'b01 || s_count !== 32'd0) begin
      errors++; $display("FAIL step_halt pc_en=%0d cause=%0d cnt=%0d want 0/1/0", pe, s_cause, s_count);
    end
  endtask

  task automatic test_host_stop();
    cycle(1, 0, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
    cycle(0, 1, 0, 4'h2, 0);
    checks++;
    if (s_pc_en !== 1'b0) begin errors++; $display("FAIL stop_same_cycle pc_en=%b want 0", s_pc_en); end
    cycle(0, 0, 0, 4'h2, 0);
    checks++;
    if (s_count !== 32'd2 || s_cause !== 2'b10 || s_done !== 1'b1) begin
      errors++; $display("FAIL stop_result cnt=%0d cause=%0d done=%b want 2/2/1", s_count, s_cause, s_done);
    end
    cycle(1, 0, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
    checks++;
    if (s_count !== 32'd0 || s_pc_en !== 1'b1 || s_cause !== 2'b00) begin
      errors++; $display("FAIL stop_resume cnt=%0d pc_en=%b cause=%0d want 0/1/0", s_count, s_pc_en, s_cause);
    end
    cycle(0, 1, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
  endtask

  task automatic test_parity();
    cycle(1, 0, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 1);
`ifdef RUN_CTRL_PARITY_TRAP_EN
    checks++;
    if (s_pc_en !== 1'b0) begin errors++; $display("FAIL parity_block pc_en=%b want 0", s_pc_en); end
    cycle(1, 0, 0, 4'h2, 0);
    cycle(0, 0, 1, 4'h2, 0);
    checks++;
    if (s_fault !== 1'b1 || s_busy !== 1'b0 || s_pc_en !== 1'b0) begin
      errors++; $display("FAIL parity_fault fault=%b busy=%b pc_en=%b want 1/0/0", s_fault, s_busy, s_pc_en);
    end
    apply_reset();
    cycle(0, 0, 0, 4'h2, 0);
    checks++;
    if (s_fault !== 1'b0) begin errors++; $display("FAIL parity_reset fault=%b want 0", s_fault); end
`else
    checks++;
    if (s_pc_en !== 1'b1) begin errors++; $display("FAIL parity_ignored pc_en=%b want 1", s_pc_en); end
    cycle(0, 0, 0, 4'h2, 0);
    checks++;
    if (s_fault !== 1'b0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL parity_nofault fault=%b busy=%b want 0/1", s_fault, s_busy);
    end
    cycle(0, 1, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
`endif
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
    opcode = 4'h2;
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({pc_en, wb_en, busy, done, fault} !== 5'b0 || cycle_count !== 32'd0 || halt_cause !== 2'b00 || halt_pc !== 32'd0) begin
      errors++; $display("FAIL async_reset flags=%b cnt=%0d cause=%0d hpc=%h want all zero",
                         {pc_en, wb_en, busy, done, fault}, cycle_count, halt_cause, halt_pc);
    end
    @(negedge clk);
    rst_n = 1; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || pc_en !== 1'b1 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL first_start busy=%b pc_en=%b cnt=%0d want 1/1/0", busy, pc_en, cycle_count);
    end
    @(posedge clk);
    #1;
    cycle(0, 1, 0, 4'h2, 0);
    cycle(0, 0, 0, 4'h2, 0);
  endtask

  task automatic test_random();
    logic        m_active, m_single, m_faulted, m_done, new_done, m_trap, m_ret;
    logic [1:0]  m_cause;
    logic [31:0] m_count, m_hpc;
    logic        st, sp, stp, par;
    logic [3:0]  op;
    for (int ep = 0; ep < 25; ep++) begin
      apply_reset();
      case ($urandom_range(3))
        0: cycle_limit = 0;
        1: cycle_limit = 1;
        2: cycle_limit = $urandom_range(6, 2);
        default: cycle_limit = $urandom_range(30, 7);
      endcase
      pc = $urandom;
      m_active = 0; m_single = 0; m_faulted = 0; m_done = 0;
      m_cause = 0; m_count = 0; m_hpc = 0;
      for (int c = 0; c < 60; c++) begin
        st  = ($urandom_range(7) == 0);
        sp  = ($urandom_range(9) == 0);
        stp = ($urandom_range(7) == 0);
        par = ($urandom_range(29) == 0);
        op  = ($urandom_range(11) == 0) ? 4'hF : 4'($urandom_range(14));
`ifdef RUN_CTRL_PARITY_TRAP_EN
        m_trap = m_active && par;
`else
        m_trap = 1'b0;
`endif
        m_ret = m_active && !m_trap && op != 4'hF && !sp;
        start = st; stop = sp; step = stp; opcode = op; parity_error = par; pc_value = pc;
        @(negedge clk);
        checks++;
        if (pc_en !== m_ret || wb_en !== m_ret) begin
          errors++; $display("FAIL rnd_pc_en ep=%0d c=%0d got=%b/%b want=%b", ep, c, pc_en, wb_en, m_ret);
        end
        checks++;
        if (busy !== m_active || done !== m_done || fault !== m_faulted) begin
          errors++; $display("FAIL rnd_status ep=%0d c=%0d got=%b%b%b want=%b%b%b", ep, c,
                             busy, done, fault, m_active, m_done, m_faulted);
        end
        checks++;
        if (halt_cause !== m_cause || cycle_count !== m_count || halt_pc !== m_hpc) begin
          errors++; $display("FAIL rnd_regs ep=%0d c=%0d cause=%0d cnt=%0d hpc=%h want %0d/%0d/%h", ep, c,
                             halt_cause, cycle_count, halt_pc, m_cause, m_count, m_hpc);
        end
        @(posedge clk);
        new_done = 0;
        if (m_faulted) begin
        end else if (!m_active) begin
          if (st || stp) begin
            m_active = 1; m_single = !st; m_count = 0; m_cause = 0;
          end
        end else if (m_trap) begin
          m_faulted = 1; m_active = 0;
        end else if (op == 4'hF) begin
          m_active = 0; m_cause = 2'd1; new_done = 1;
        end else if (sp) begin
          m_active = 0; m_cause = 2'd2; new_done = 1;
        end else begin
          m_count = m_count + 1;
          if (cycle_limit != 0 && m_count == cycle_limit) begin
            m_active = 0; m_cause = 2'd3; new_done = 1;
          end else if (m_single) begin
            m_active = 0; m_cause = 2'd2; new_done = 1;
          end
        end
        if (m_done) m_hpc = pc;
        m_done = new_done;
        if (m_ret) pc = pc + 32'd1;
        #1;
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_halt_opcode();
    test_cycle_limit();
    test_single_step();
    test_host_stop();
    test_parity();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
